// File: rtl/bcla16_seq_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// bcla16_seq_ctrl
//
// Multi-precision add/subtract sequencer. One 16-bit block carry-lookahead
// adder (bcla16) is time-shared across WORDS limbs. The limbs are processed
// least significant first, and the carry is chained through a register.
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   op_a/op_b/sub valid
//   in_ready   out  ready to accept an operation (IDLE only)
//   sub        in   0: A+B, 1: A-B (A + ~B + 1)
//   op_a       in   operand A, 16*WORDS bits
//   op_b       in   operand B, 16*WORDS bits
//   out_valid  out  result/cout/ovf valid (DONE)
//   out_ready  in   consumer accepts the result
//   result     out  sum/difference modulo 2^(16*WORDS)
//   cout       out  carry out of the top limb (1 = no borrow on subtract)
//   ovf        out  two's-complement overflow of the full-width operation
//   busy       out  high in RUN and DONE
// ---------------------------------------------------------------------------

// 16-bit block carry-lookahead adder: four 4-bit groups with a second
// lookahead level across the groups. g/p are the block generate/propagate,
// so the caller forms the carry-out as g | (p & cin).
module bcla16 (
    output logic        g,
    output logic        p,
    output logic [15:0] sum,
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        cin
);
    logic [15:0] gb;
    logic [15:0] pb;
    logic [3:0]  gg;
    logic [3:0]  gp;
    logic [3:0]  gc;
    logic [15:0] c;

    assign gb = A & B;
    assign pb = A ^ B;

    always_comb begin
        gg = '0;
        gp = '0;
        for (int k = 0; k < 4; k++) begin
            gg[k] = gb[4*k+3]
                  | (pb[4*k+3] & gb[4*k+2])
                  | (pb[4*k+3] & pb[4*k+2] & gb[4*k+1])
                  | (pb[4*k+3] & pb[4*k+2] & pb[4*k+1] & gb[4*k]);
            gp[k] = &pb[4*k+3 -: 4];
        end
    end

    // Group carries fully expanded from cin so no carry waits on another.
    assign gc[0] = cin;
    assign gc[1] = gg[0] | (gp[0] & cin);
    assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
    assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
                 | (gp[2] & gp[1] & gp[0] & cin);

    always_comb begin
        c = '0;
        for (int k = 0; k < 4; k++) begin
            c[4*k]   = gc[k];
            c[4*k+1] = gb[4*k] | (pb[4*k] & gc[k]);
            c[4*k+2] = gb[4*k+1] | (pb[4*k+1] & gb[4*k])
                     | (pb[4*k+1] & pb[4*k] & gc[k]);
            c[4*k+3] = gb[4*k+2] | (pb[4*k+2] & gb[4*k+1])
                     | (pb[4*k+2] & pb[4*k+1] & gb[4*k])
                     | (pb[4*k+2] & pb[4*k+1] & pb[4*k] & gc[k]);
        end
    end

    assign sum = pb ^ c;
    assign g   = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
               | (gp[3] & gp[2] & gp[1] & gg[0]);
    assign p   = &gp;
endmodule

module bcla16_seq_ctrl #(
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  sub,
    input  logic [16*WORDS-1:0]   op_a,
    input  logic [16*WORDS-1:0]   op_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [16*WORDS-1:0]   result,
    output logic                  cout,
    output logic                  ovf,
    output logic                  busy
);
    localparam int         W        = 16 * WORDS;
    localparam logic [2:0] LAST_IDX = 3'(WORDS - 1);

    if (WORDS < 1 || WORDS > 8) begin : g_bad_words
        $error("bcla16_seq_ctrl: WORDS must be in 1..8");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e       state_q, state_d;
    logic [W-1:0] a_q, a_d;
    logic [W-1:0] b_q, b_d;
    logic [W-1:0] res_q, res_d;
    logic         c_q, c_d;
    logic         ovf_q, ovf_d;
    logic [2:0]   idx_q, idx_d;

    logic [15:0]  limb_a;
    logic [15:0]  limb_b;
    logic [15:0]  limb_sum;
    logic         limb_g;
    logic         limb_p;
    logic         limb_cout;

    // Limb multiplexer: only indices that exist for this WORDS are decoded.
    always_comb begin
        limb_a = '0;
        limb_b = '0;
        for (int w = 0; w < WORDS; w++) begin
            if (idx_q == 3'(w)) begin
                limb_a = a_q[16*w +: 16];
                limb_b = b_q[16*w +: 16];
            end
        end
    end

    bcla16 u_add (
        .g   (limb_g),
        .p   (limb_p),
        .sum (limb_sum),
        .A   (limb_a),
        .B   (limb_b),
        .cin (c_q)
    );

    assign limb_cout = limb_g | (limb_p & c_q);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        c_d     = c_q;
        ovf_d   = ovf_q;
        idx_d   = idx_q;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = op_a;
                    // Subtract as A + ~B + 1: the +1 enters as the first carry.
                    b_d     = sub ? ~op_b : op_b;
                    c_d     = sub;
                    idx_d   = '0;
                    res_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                for (int w = 0; w < WORDS; w++) begin
                    if (idx_q == 3'(w)) begin
                        res_d[16*w +: 16] = limb_sum;
                    end
                end
                c_d = limb_cout;
                if (idx_q == LAST_IDX) begin
                    // Operands agree in sign but the sum does not.
                    ovf_d   = (limb_a[15] ~^ limb_b[15]) & (limb_sum[15] ^ limb_a[15]);
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            c_q     <= 1'b0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            c_q     <= c_d;
            ovf_q   <= ovf_d;
            idx_q   <= idx_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_RUN) || (state_q == S_DONE);
    assign result    = res_q;
    assign cout      = c_q;
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_bcla16_seq_ctrl.sv
`timescale 1ns/1ps
// Directed bench for bcla16_seq_ctrl with WORDS = 4.
module tb_bcla16_seq_ctrl;
    localparam int WORDS = 4;
    localparam int W     = 16 * WORDS;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic         sub;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;
    logic         busy;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    bcla16_seq_ctrl #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sub       (sub),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accept edge.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        op_a     = a;
        op_b     = b;
        sub      = s;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Counts edges after the accept edge until out_valid, bounded.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input logic [W-1:0] exp_res,
                          input logic exp_c, input logic exp_o);
        int lat;
        start_op(a, b, s);
        check_eq({tag, ".busy_run"}, 64'(busy), 64'd1);
        check_eq({tag, ".in_ready_run"}, 64'(in_ready), 64'd0);
        wait_done(lat);
        check_eq({tag, ".latency"}, 64'(lat), 64'd4);
        check_eq({tag, ".result"}, result, exp_res);
        check_eq({tag, ".cout"}, 64'(cout), 64'(exp_c));
        check_eq({tag, ".ovf"}, 64'(ovf), 64'(exp_o));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq({tag, ".out_valid_after"}, 64'(out_valid), 64'd0);
        check_eq({tag, ".in_ready_after"}, 64'(in_ready), 64'd1);
        check_eq({tag, ".result_held"}, result, exp_res);
    endtask

    initial begin
        int  lat;
        logic saw_valid;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        sub       = 1'b0;
        op_a      = '0;
        op_b      = '0;
        out_ready = 1'b0;

        #2;
        check_eq("rst.in_ready", 64'(in_ready), 64'd1);
        check_eq("rst.out_valid", 64'(out_valid), 64'd0);
        check_eq("rst.busy", 64'(busy), 64'd0);
        check_eq("rst.result", result, 64'd0);
        check_eq("rst.cout", 64'(cout), 64'd0);
        check_eq("rst.ovf", 64'(ovf), 64'd0);

        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("add_limb_carry", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0,
               64'h0000_0000_0001_0000, 1'b0, 1'b0);
        run_op("add_ripple_all", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0,
               64'h0, 1'b1, 1'b0);
        run_op("add_pos_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0,
               64'h8000_0000_0000_0000, 1'b0, 1'b1);
        run_op("sub_borrow", 64'd5, 64'd7, 1'b1,
               64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
        run_op("sub_no_borrow", 64'd7, 64'd5, 1'b1, 64'h2, 1'b1, 1'b0);
        run_op("sub_neg_ovf", 64'h8000_0000_0000_0000, 64'h1, 1'b1,
               64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);

        // Backpressure: DONE held, inputs churned, nothing may move.
        start_op(64'd7, 64'd5, 1'b1);
        wait_done(lat);
        check_eq("bp.latency", 64'(lat), 64'd4);
        for (int i = 0; i < 10; i++) begin
            in_valid = ~in_valid;
            op_a     = {$urandom, $urandom};
            op_b     = {$urandom, $urandom};
            sub      = ~sub;
            @(posedge clk); #1;
            check_eq("bp.result", result, 64'h2);
            check_eq("bp.cout", 64'(cout), 64'd1);
            check_eq("bp.ovf", 64'(ovf), 64'd0);
            check_eq("bp.out_valid", 64'(out_valid), 64'd1);
            check_eq("bp.in_ready", 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq("bp.handoff_out_valid", 64'(out_valid), 64'd0);
        check_eq("bp.handoff_in_ready", 64'(in_ready), 64'd1);
        check_eq("bp.handoff_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        check_eq("bp.idle_stays", 64'(in_ready), 64'd1);
        check_eq("bp.idle_result", result, 64'h2);

        // Asynchronous reset in RUN with idx = 2.
        start_op(64'h1111_2222_3333_4444, 64'h0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_eq("arst.partial", result, 64'h0000_0000_3333_4444);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst.result", result, 64'h0);
        check_eq("arst.busy", 64'(busy), 64'd0);
        check_eq("arst.in_ready", 64'(in_ready), 64'd1);
        check_eq("arst.out_valid", 64'(out_valid), 64'd0);
        check_eq("arst.cout", 64'(cout), 64'd0);
        check_eq("arst.ovf", 64'(ovf), 64'd0);
        saw_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (out_valid) saw_valid = 1'b1;
        end
        check_eq("arst.no_out_valid", 64'(saw_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op("post_rst", 64'h1234, 64'h1, 1'b0, 64'h1235, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
